mul_div_unit: RTL and testbench

- Iterative 16-bit unsigned multiply/divide unit.
- Sits between the register file read ports and its write port, as the multi-cycle execution path for MUL/DIV.
- Takes the two register read operands and a destination index, computes over 16 iterations, then issues a one-cycle write-back strobe: result_lo on the data_write path, reg_write_out on the reg_write path.
- The control unit stalls the PC while busy is high.

---
 rtl/mul_div_unit.sv | 110 +++++++++++
 tb/tb_mul_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide,
// WIDTH iterations per operation followed by a one-cycle write-back strobe.
module mul_div_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              busy,
  output logic              done,
  output logic              reg_write_out,
  output logic [ADDR_W-1:0] dest_out,
  output logic [WIDTH-1:0]  result_lo,
  output logic [WIDTH-1:0]  result_hi,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic               op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc, acc_step, shifted;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic               accept, last_iter;

  assign accept        = start && (state != RUN);
  assign last_iter     = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign reg_write_out = done;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Multiply: acc[2W-1:W] accumulates, acc[W-1:0] holds the multiplier being shifted out.
  // Divide: acc[2W:W] is the partial remainder, acc[W-1:0] shifts dividend out / quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_r : WIDTH'(0))};
    shifted  = {acc[2*WIDTH-1:0], 1'b0};
    rem_sh   = shifted[2*WIDTH:WIDTH];
    acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
    if (op_r) begin
      if (rem_sh >= {1'b0, b_r})
        acc_step = {rem_sh - {1'b0, b_r}, shifted[WIDTH-1:1], 1'b1};
      else
        acc_step = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      acc       <= '0;
      dest_out  <= '0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      op_r     <= op;
      a_r      <= operand_a;
      b_r      <= operand_b;
      dest_out <= dest_in;
      cnt      <= '0;
      acc      <= {(WIDTH + 1)'(0), (op ? operand_a : operand_b)};
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
      if (last_iter) begin
        if (op_r && (b_r == '0)) begin
          result_lo <= '1;
          result_hi <= a_r;
          div_zero  <= 1'b1;
        end else begin
          result_lo <= acc_step[WIDTH-1:0];
          result_hi <= acc_step[2*WIDTH-1:WIDTH];
          div_zero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random operations against an
// arithmetic reference model, plus start-while-busy, back-to-back and reset scenarios.
module tb_mul_div_unit;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, op;
  logic [W-1:0]  a, b;
  logic [AW-1:0] dest;
  logic          busy, done, reg_write_out, div_zero;
  logic [AW-1:0] dest_out;
  logic [W-1:0]  result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .dest_in(dest),
    .busy(busy), .done(done), .reg_write_out(reg_write_out),
    .dest_out(dest_out), .result_lo(result_lo), .result_hi(result_hi),
    .div_zero(div_zero)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic o, input logic [W-1:0] x, y,
                                output logic [W-1:0] lo, hi, output logic dz);
    logic [2*W-1:0] p;
    if (!o) begin
      p  = (2*W)'(x) * (2*W)'(y);
      lo = p[W-1:0];
      hi = p[2*W-1:W];
      dz = 1'b0;
    end else if (y == 0) begin
      lo = 16'hFFFF;
      hi = x;
      dz = 1'b1;
    end else begin
      lo = x / y;
      hi = x % y;
      dz = 1'b0;
    end
  endfunction

  // Issues one operation (called at posedge+1) and waits for done, with a cycle bound.
  // lat counts edges from acceptance edge to the edge that raises done, inclusive.
  task automatic run_op(input logic o, input logic [W-1:0] x, y, input logic [AW-1:0] d,
                        output int lat, output logic [W-1:0] lo, hi,
                        output logic dz, output logic [AW-1:0] dst, output logic wr);
    op = o; a = x; b = y; dest = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); dest = AW'($urandom); op = ~o;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    lo = result_lo; hi = result_hi; dz = div_zero; dst = dest_out; wr = reg_write_out;
  endtask

  task automatic compare_op(input string name, input logic o, input logic [W-1:0] x, y,
                            input logic [AW-1:0] d);
    int            lat;
    logic [W-1:0]  lo, hi, elo, ehi;
    logic          dz, edz, wr;
    logic [AW-1:0] dst;
    run_op(o, x, y, d, lat, lo, hi, dz, dst, wr);
    model(o, x, y, elo, ehi, edz);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL %s latency: got %0d expected 17", name, lat); end
    checks++;
    if ({lo, hi, dz} !== {elo, ehi, edz}) begin
      errors++;
      $display("FAIL %s result (op=%0d a=%h b=%h): got lo=%h hi=%h dz=%b expected lo=%h hi=%h dz=%b",
               name, o, x, y, lo, hi, dz, elo, ehi, edz);
    end
    checks++;
    if ({dst, wr} !== {d, 1'b1}) begin
      errors++;
      $display("FAIL %s writeback: got dest=%h wr=%b expected dest=%h wr=1", name, dst, wr, d);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, reg_write_out, busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s pulse width: got done=%b wr=%b busy=%b expected 0 0 0",
               name, done, reg_write_out, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, reg_write_out, dest_out, result_lo, result_hi, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b wr=%b dest=%h lo=%h hi=%h dz=%b expected all 0",
               busy, done, reg_write_out, dest_out, result_lo, result_hi, div_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    compare_op("mul_basic", 1'b0, 16'h1234, 16'h0010, 4'h7);
    compare_op("mul_max",   1'b0, 16'hFFFF, 16'hFFFF, 4'h3);
    compare_op("div_100_7", 1'b1, 16'd100,  16'd7,    4'hA);
    compare_op("div_small", 1'b1, 16'h0005, 16'h0009, 4'h1);
    compare_op("div_zero",  1'b1, 16'h1234, 16'h0000, 4'hF);
    compare_op("mul_clear", 1'b0, 16'd3,    16'd3,    4'h2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic          o;
      logic [W-1:0]  x, y;
      o = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = W'($urandom_range(1, 15));
        2: x = W'($urandom_range(0, 15));
        default: ;
      endcase
      compare_op("random", o, x, y, AW'($urandom));
    end
  endtask

  task automatic test_start_while_busy();
    int            ndone;
    logic [W-1:0]  lo, hi;
    op = 1'b0; a = 16'd2; b = 16'd3; dest = 4'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 1'b1; a = 16'h7777; b = 16'h0003; dest = 4'hC; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lo = '0; hi = '0;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) begin ndone++; lo = result_lo; hi = result_hi; end
      @(posedge clk); #1;
    end
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL busy_ignore count: got %0d dones expected 1", ndone); end
    checks++;
    if ({lo, hi} !== {16'd6, 16'd0}) begin
      errors++;
      $display("FAIL busy_ignore result: got lo=%h hi=%h expected lo=0006 hi=0000", lo, hi);
    end
  endtask

  task automatic test_back_to_back();
    int            lat;
    logic [W-1:0]  lo, hi;
    logic          dz, wr;
    logic [AW-1:0] dst;
    run_op(1'b0, 16'h0100, 16'h0023, 4'h4, lat, lo, hi, dz, dst, wr);
    checks++;
    if ({lo, hi, dst} !== {16'h2300, 16'h0000, 4'h4}) begin
      errors++;
      $display("FAIL b2b first: got lo=%h hi=%h dest=%h expected 2300 0000 4", lo, hi, dst);
    end
    // still in the done cycle: hold start so it is sampled at the edge leaving DONE
    op = 1'b1; a = 16'd1000; b = 16'd33; dest = 4'h9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL b2b latency: got %0d expected 17", lat); end
    checks++;
    if ({result_lo, result_hi, dest_out, div_zero} !== {16'd30, 16'd10, 4'h9, 1'b0}) begin
      errors++;
      $display("FAIL b2b second: got lo=%h hi=%h dest=%h dz=%b expected 001e 000a 9 0",
               result_lo, result_hi, dest_out, div_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int npulse;
    op = 1'b0; a = 16'hABCD; b = 16'h1234; dest = 4'h6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, reg_write_out, dest_out, result_lo, result_hi, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid state: got busy=%b done=%b wr=%b dest=%h lo=%h hi=%h dz=%b expected all 0",
               busy, done, reg_write_out, dest_out, result_lo, result_hi, div_zero);
    end
    rst = 1'b0;
    npulse = 0;
    for (int c = 0; c < 20; c++) begin
      if (done !== 1'b0 || reg_write_out !== 1'b0 || busy !== 1'b0) npulse++;
      @(posedge clk); #1;
    end
    checks++;
    if (npulse !== 0) begin errors++; $display("FAIL reset_mid activity: got %0d active cycles expected 0", npulse); end
  endtask

  task automatic test_reset_with_start();
    int nact;
    op = 1'b0; a = 16'd5; b = 16'd5; dest = 4'h8; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    nact = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) nact++;
      @(posedge clk); #1;
    end
    checks++;
    if (nact !== 0) begin errors++; $display("FAIL rst_start: got %0d active cycles expected 0", nact); end
    checks++;
    if ({result_lo, dest_out} !== '0) begin
      errors++;
      $display("FAIL rst_start outputs: got lo=%h dest=%h expected 0 0", result_lo, dest_out);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
